// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Holds default sizing, the operation encoding and the geometry check.
package rca_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple of single-bit full adders.
// Exposes the carry into the top bit so the last stage can derive signed overflow.
module rca_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per stage,
// registered carry between stages, whole-pipe valid/ready stall.
module pipelined_rca
  import rca_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!width_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_rca: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  op_e              mode;
  logic             adv;
  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;

  assign mode     = op_e'(sub);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign y_eff    = (mode == OP_SUB) ? ~y : y;
  assign cin_eff  = (mode == OP_SUB) ? 1'b1 : cin;

  // Each stage keeps only the operand bits above its chunk; finished low
  // result bits accumulate in r_q, growing by CHUNK per stage.
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;

    logic [CHUNK-1:0] xa, ya, sum;
    logic             ci, vi, co, cm;
    logic [DONE-1:0]  r_d;

    rca_chunk #(.W(CHUNK)) u_chunk (
      .a        (xa),
      .b        (ya),
      .ci       (ci),
      .sum      (sum),
      .cout     (co),
      .c_msb_in (cm)
    );

    if (k == 0) begin : g_head
      assign xa  = x[CHUNK-1:0];
      assign ya  = y_eff[CHUNK-1:0];
      assign ci  = cin_eff;
      assign vi  = in_valid;
      assign r_d = sum;
    end else begin : g_body
      assign xa  = g_stage[k-1].g_fwd.xr_q[CHUNK-1:0];
      assign ya  = g_stage[k-1].g_fwd.yr_q[CHUNK-1:0];
      assign ci  = g_stage[k-1].g_fwd.c_q;
      assign vi  = g_stage[k-1].g_fwd.v_q;
      assign r_d = {sum, g_stage[k-1].g_fwd.r_q};
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int REM = WIDTH - DONE;

      logic [REM-1:0]  xr_d, yr_d, xr_q, yr_q;
      logic [DONE-1:0] r_q;
      logic            v_q, c_q;

      if (k == 0) begin : g_src
        assign xr_d = x[WIDTH-1:CHUNK];
        assign yr_d = y_eff[WIDTH-1:CHUNK];
      end else begin : g_src
        assign xr_d = g_stage[k-1].g_fwd.xr_q[REM+CHUNK-1:CHUNK];
        assign yr_d = g_stage[k-1].g_fwd.yr_q[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)        v_q <= 1'b0;
        else if (flush) v_q <= 1'b0;
        else if (adv)   v_q <= vi;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          c_q  <= co;
          r_q  <= r_d;
          xr_q <= xr_d;
          yr_q <= yr_d;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          s         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else begin
          if (flush)    out_valid <= 1'b0;
          else if (adv) out_valid <= vi;
          if (adv) begin
            s    <= r_d;
            cout <= co;
            ovf  <= co ^ cm;
            zero <= (r_d == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca: three instances (4, 1 and 32 stages)
// share stimulus; vector table plus stream/stall, flush and reset sequences.
module tb_pipelined_rca;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, cin, sub, flush;
  logic [W-1:0] x, y;

  logic         rdy4, rdy1, rdy32, ov4, ov1, ov32;
  logic         c4, c1, c32, f4, f1, f32, z4, z1, z32;
  logic [W-1:0] s4, s1, s32;

  logic [2:0]   rdy, ov, cv, fv, zv;
  logic [W-1:0] sv [3];

  assign rdy   = {rdy32, rdy1, rdy4};
  assign ov    = {ov32, ov1, ov4};
  assign cv    = {c32, c1, c4};
  assign fv    = {f32, f1, f4};
  assign zv    = {z32, z1, z4};
  assign sv[0] = s4;
  assign sv[1] = s1;
  assign sv[2] = s32;

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(W), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .x(x), .y(y),
    .cin(cin), .sub(sub), .flush(flush), .out_valid(ov4), .out_ready(out_ready),
    .s(s4), .cout(c4), .ovf(f4), .zero(z4));

  pipelined_rca #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .x(x), .y(y),
    .cin(cin), .sub(sub), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .s(s1), .cout(c1), .ovf(f1), .zero(z1));

  pipelined_rca #(.WIDTH(W), .STAGES(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .x(x), .y(y),
    .cin(cin), .sub(sub), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .s(s32), .cout(c32), .ovf(f32), .zero(z32));

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_exp(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int           lat [3];
    logic [W-1:0] rs  [3];
    logic [2:0]   rc, ro, rz;
    logic [2:0]   seen;
    seen = '0;
    rc = '0; ro = '0; rz = '0;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0;
      rs[d]  = '0;
    end
    x = v.x; y = v.y; cin = v.cin; sub = v.sub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d] = 1'b1;
          lat[d]  = c;
          rs[d]   = sv[d];
          rc[d]   = cv[d];
          ro[d]   = fv[d];
          rz[d]   = zv[d];
        end
      end
      if (seen == 3'b111) break;
      step();
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("v%0d d%0d latency", id, d), lat[d], lat_exp(d));
      chk($sformatf("v%0d d%0d s", id, d), rs[d], v.s);
      chk($sformatf("v%0d d%0d cout", id, d), rc[d], v.c);
      chk($sformatf("v%0d d%0d ovf", id, d), ro[d], v.o);
      chk($sformatf("v%0d d%0d zero", id, d), rz[d], v.z);
    end
  endtask

  vec_t         tbl [10];
  vec_t         extra;
  logic [W-1:0] expq [$];
  logic [W-1:0] held;
  int           sent, got;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    flush = 1'b0; x = '0; y = '0; held = '0;

    //          x             y             cin   sub   s             c     o     z
    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h0000_000A, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    extra  = '{32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0};

    // reset state
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d out_valid", d), ov[d], 1'b0);
      chk($sformatf("reset d%0d s", d), sv[d], '0);
      chk($sformatf("reset d%0d cout", d), cv[d], 1'b0);
      chk($sformatf("reset d%0d ovf", d), fv[d], 1'b0);
      chk($sformatf("reset d%0d zero", d), zv[d], 1'b0);
    end
    rst = 1'b0;
    step();
    chk("in_ready after reset", rdy, 3'b111);

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // back-to-back stream with a 3-cycle stall on dut4
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      out_ready = !(cyc >= 7 && cyc <= 9);
      if (sent < 10) begin
        in_valid = 1'b1; x = W'(sent); y = W'(3 * sent); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (ov[0] && out_ready) begin
        if (expq.size() == 0) begin
          chk("stream unexpected beat", sv[0], '1);
        end else begin
          chk($sformatf("stream beat %0d s", got), sv[0], expq.pop_front());
        end
        got++;
      end
      if (!out_ready) begin
        chk($sformatf("stall cyc%0d in_ready", cyc), rdy[0], 1'b0);
        chk($sformatf("stall cyc%0d out_valid", cyc), ov[0], 1'b1);
        if (cyc == 7) held = sv[0];
        else          chk($sformatf("stall cyc%0d s stable", cyc), sv[0], held);
      end
      if (in_valid && rdy[0]) begin
        expq.push_back(W'(4 * sent));
        sent++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream beats received", got, 10);
    chk("stream beats sent", sent, 10);

    // flush with 3 beats in flight plus a 4th presented alongside
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = W'(i + 1); y = 32'h1; cin = 1'b0; sub = 1'b0;
      step();
    end
    x = 32'h55; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flush cyc%0d out_valid", i), ov, 3'b000);
      step();
    end

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = W'(32'h100 + i + 1); y = 32'h1; cin = 1'b0; sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", ov[0], 1'b1);
    chk("pre-reset s", sv[0], 32'h102);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async rst d%0d out_valid", d), ov[d], 1'b0);
      chk($sformatf("async rst d%0d s", d), sv[d], '0);
      chk($sformatf("async rst d%0d cout", d), cv[d], 1'b0);
      chk($sformatf("async rst d%0d ovf", d), fv[d], 1'b0);
      chk($sformatf("async rst d%0d zero", d), zv[d], 1'b0);
    end
    @(posedge clk);
    #4;
    rst = 1'b0;
    step();
    chk("in_ready after async rst", rdy, 3'b111);
    run_vec(extra, 10);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; generation after the fixed 8-bit combinational RCA.
- Splits a WIDTH-bit operation into STAGES ripple chunks, one chunk per pipeline stage, with registered carry between chunks.
- Valid/ready handshakes on input and output sustain one operation per cycle at full throughput.
- Sits between operand-producing datapath blocks and result consumers where an 8-bit single-cycle adder no longer meets timing.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and ripple chunks; 1..WIDTH.
- CHUNK, WIDTH/STAGES, bits per chunk; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = x+y+cin; 1 = x-y (x + ~y + 1).
- flush  input  1  synchronous clear of all in-flight beats.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  s == 0.

Behaviour:
- Reset (async assert, sync-safe deassert inside the block not required): all stage valid bits, out_valid, s, cout, ovf and zero go to 0. in_ready reads 1 one cycle after reset deasserts and while rst=0 with an empty pipe.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Advance: adv = !out_valid || out_ready. in_ready = adv. When adv=1, every stage register loads from its predecessor, including bubbles. When adv=0, the whole pipe holds and outputs stay stable.
- Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] from the operand bits carried forward plus the registered carry from stage k-1. Stage 0 uses cin_eff = sub ? 1 : cin and y_eff = sub ? ~y : y.
- Operands are skewed: stage k stores only the operand bits still needed by later stages (upper bits). Lower result bits already computed travel forward in the result register.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles later when out_ready stays 1. With STAGES=1 the result is registered once, so latency is 1.
- Throughput: 1 beat per cycle. Back-pressure stalls all stages in lockstep; no beat is dropped or duplicated.
- ovf, zero and cout are computed in the last stage and registered with s.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only via cout and ovf.
- flush=1: all stage valid bits and out_valid clear on the next edge, regardless of out_ready. A beat presented with in_valid in the same cycle is discarded (in_ready still reads adv, but the beat is dropped). Data registers may keep stale values.
- rst asserted mid-operation discards all in-flight beats immediately.
- Simultaneous output-accept and input-accept is legal every cycle; pipe occupancy stays constant.

Decomposition:
- Shared package rca_pkg holds DEFAULT_WIDTH=32, DEFAULT_STAGES=4, the mode encoding (OP_ADD=0, OP_SUB=1), and a function checking WIDTH % STAGES == 0 for an elaboration-time assertion.
- Sub-module rca_chunk: combinational CHUNK-bit ripple of single-bit full adders, with outputs sum, cout, and c_msb_in (carry into top bit, used for ovf). Instantiated once per stage with a generate loop.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1: x=0x0000_00FF, y=0x0000_0001, cin=0, sub=0 -> after exactly 4 cycles s=0x0000_0100, cout=0, ovf=0, zero=0.
- x=0xFFFF_FFFF, y=0x0000_0001, sub=0 -> s=0, cout=1, zero=1, ovf=0. This checks carry rippling through all 4 chunk registers.
- sub=1, x=0x8000_0000, y=1 -> s=0x7FFF_FFFF, cout=1, ovf=1. Then sub=1, x=5, y=7 -> s=0xFFFF_FFFE, cout=0, ovf=0.
- Stream 10 back-to-back beats (x=i, y=i·3), then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, s stable, all 10 results arrive in order with correct values.
- Fill the pipe with 3 beats, pulse flush for 1 cycle alongside a new in_valid beat -> out_valid stays 0 for the next 4 cycles and none of the 4 beats emerges.
- Assert rst asynchronously between clock edges with 2 beats in flight -> out_valid, s, cout, ovf and zero read 0 immediately. After release, a new beat x=2, y=2 yields s=4 after 4 cycles. Repeat the first scenario with STAGES=1 and with STAGES=32, checking latencies of 1 and 32.
